dec_pipe: RTL



---
 rtl/trng_cipher_pkg.sv | 30 +++
 rtl/inv_round_stage.sv | 31 +++
 rtl/dec_pipe.sv | 78 +++++++
 3 files changed

// File: rtl/trng_cipher_pkg.sv
// Shared cipher definitions for the TRNG whitening encryptor and its decryptor.
// Both directions use the same round key schedule and constants from here.
package trng_cipher_pkg;

    localparam int          ROUNDS = 12;
    localparam logic [31:0] DELTA  = 32'h9E3779B9;
    localparam int          ROT    = 5;

    // Key byte XOR round index, replicated across the word.
    function automatic logic [31:0] round_key(input logic [7:0] k, input int r);
        logic [7:0] b;
        b = k ^ r[7:0];
        return {4{b}};
    endfunction

    // Forward round: rotate-left after key mix, then add DELTA.
    function automatic logic [31:0] fwd_round(input logic [31:0] x, input logic [7:0] k, input int r);
        logic [31:0] t;
        t = x ^ round_key(k, r);
        return ((t << ROT) | (t >> (32 - ROT))) + DELTA;
    endfunction

    // Inverse round: undo the add (mod 2^32), rotate right, then unmix the key.
    function automatic logic [31:0] inv_round(input logic [31:0] y, input logic [7:0] k, input int r);
        logic [31:0] t;
        t = y - DELTA;
        return ((t >> ROT) | (t << (32 - ROT))) ^ round_key(k, r);
    endfunction

endpackage

// File: rtl/inv_round_stage.sv
// One registered inverse round. The key and valid flag travel with the word so
// every word is decrypted with its own key regardless of what follows it.
module inv_round_stage #(
    parameter int RND = 0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        adv,
    input  logic [31:0] prev_data,
    input  logic [7:0]  prev_key,
    input  logic        prev_valid,
    output logic [31:0] data,
    output logic [7:0]  key,
    output logic        valid
);
    import trng_cipher_pkg::*;

    // Shift the previous stage in, decrypted by one round, whenever the pipe advances.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            data  <= '0;
            key   <= '0;
            valid <= 1'b0;
        end else if (adv) begin
            data  <= inv_round(prev_data, prev_key, RND);
            key   <= prev_key;
            valid <= prev_valid;
        end
    end

endmodule

// File: rtl/dec_pipe.sv
// 12-round pipelined decryptor with valid/ready handshake. The whole pipe
// advances or stalls as one unit; bubbles are held, never squeezed out, so a
// stall adds exactly one cycle to every in-flight word.
module dec_pipe (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] D_IN,
    input  logic [7:0]  K_IN,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [31:0] D_OUT,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        BUSY
);
    import trng_cipher_pkg::*;

    // Index 0 is the input stage; index j+1 is round stage j.
    logic [31:0] chain_data  [0:ROUNDS];
    logic [7:0]  chain_key   [0:ROUNDS];
    logic        chain_valid [0:ROUNDS];

    logic        adv;
    logic [7:0]  unused_last_key;

    // Advance whenever the output slot is empty or being drained this cycle.
    always_comb begin
        adv      = !chain_valid[ROUNDS] || OUT_READY;
        IN_READY = adv;
    end

    // Input stage: capture the offered word, or a bubble if nothing is accepted.
    // Data/key are only loaded for real words to avoid needless toggling.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            chain_data[0]  <= '0;
            chain_key[0]   <= '0;
            chain_valid[0] <= 1'b0;
        end else if (adv) begin
            chain_valid[0] <= IN_VALID;
            if (IN_VALID) begin
                chain_data[0] <= D_IN;
                chain_key[0]  <= K_IN;
            end
        end
    end

    // Round stage j undoes encryption round ROUNDS-1-j, last round first.
    for (genvar j = 0; j < ROUNDS; j++) begin : g_round
        inv_round_stage #(
            .RND(ROUNDS - 1 - j)
        ) u_stage (
            .CLK        (CLK),
            .RST_N      (RST_N),
            .adv        (adv),
            .prev_data  (chain_data[j]),
            .prev_key   (chain_key[j]),
            .prev_valid (chain_valid[j]),
            .data       (chain_data[j+1]),
            .key        (chain_key[j+1]),
            .valid      (chain_valid[j+1])
        );
    end

    // The final stage's key has no consumer.
    assign unused_last_key = chain_key[ROUNDS];

    // Output from the last round stage; BUSY is any stage holding a real word.
    always_comb begin
        D_OUT     = chain_data[ROUNDS];
        OUT_VALID = chain_valid[ROUNDS];
        BUSY      = 1'b0;
        for (int i = 0; i <= ROUNDS; i++) begin
            BUSY = BUSY | chain_valid[i];
        end
    end

endmodule
